// File: rtl/layer_scanner.sv
// layer_scanner: one-hot LED cube layer driver with a programmable hold time.
// Manual mode drives a single requested layer once; auto mode scans every
// layer continuously and pulses frame_done after the last layer of a frame.
// Compile-time option: define LAYER_BLANK_EN to insert BLANK_CYCLES of
// dead time (all layers off) before every layer as anti-ghosting guard.
module layer_scanner #(
  parameter int   NUM_LAYERS   = 8,
  localparam int  LAYER_W      = $clog2(NUM_LAYERS),
  parameter int   CNT_W        = 16,
  parameter int   HOLD_CYCLES  = 2929,
  parameter int   BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LAYER_W-1:0]    layer_i,
  input  logic                  auto_en,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_done,
  output logic                  err,
  output logic [LAYER_W-1:0]    cur_layer,
  output logic [NUM_LAYERS-1:0] layer_out
);

  // State encoding kept as plain constants for compatibility with older tools.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Dead-time insertion is a build-time choice; with it off the BLANK state
  // is never entered and its logic is trimmed away as unreachable.
`ifdef LAYER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]   HOLD_LAST      = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST     = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER     = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [LAYER_W:0]   NUM_LAYERS_EXT = (LAYER_W + 1)'(NUM_LAYERS);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               auto_flag;
  logic               layer_ok;
  logic [LAYER_W-1:0] next_layer;

  // Decode a layer index into its one-hot drive pattern.
  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [LAYER_W-1:0] idx);
    logic [NUM_LAYERS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx == LAYER_W'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Range check of a manual request; NUM_LAYERS need not be a power of two,
  // so the index width alone does not guarantee a legal layer.
  assign layer_ok = ({1'b0, layer_i} < NUM_LAYERS_EXT);

  // Successor layer for the auto scan, wrapping after the last layer.
  assign next_layer = (cur_layer == LAST_LAYER) ? '0 : cur_layer + 1'b1;

  // Busy is a pure decode of the registered state, so it is glitch-free.
  assign busy = (state != ST_IDLE);

  // Main sequencer: state, hold/blank counter, layer index and all pulses.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value of the registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      auto_flag  <= 1'b0;
      cur_layer  <= '0;
      layer_out  <= '0;
      done       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Pulses default low and are raised for exactly one cycle below.
      done       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (auto_en) begin
            // Auto has priority; a simultaneous start is dropped.
            auto_flag <= 1'b1;
            cur_layer <= '0;
            state     <= BLANK_EN ? ST_BLANK : ST_ACTIVE;
            layer_out <= BLANK_EN ? '0 : onehot('0);
          end else if (start) begin
            if (layer_ok) begin
              auto_flag <= 1'b0;
              cur_layer <= layer_i;
              state     <= BLANK_EN ? ST_BLANK : ST_ACTIVE;
              layer_out <= BLANK_EN ? '0 : onehot(layer_i);
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt       <= '0;
            state     <= ST_ACTIVE;
            layer_out <= onehot(cur_layer);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (cnt == HOLD_LAST) begin
            cnt        <= '0;
            done       <= 1'b1;
            frame_done <= auto_flag && (cur_layer == LAST_LAYER);
            if (auto_flag && auto_en) begin
              // Continue the scan with no idle gap between layers.
              cur_layer <= next_layer;
              state     <= BLANK_EN ? ST_BLANK : ST_ACTIVE;
              layer_out <= BLANK_EN ? '0 : onehot(next_layer);
            end else begin
              // cur_layer deliberately keeps the last driven layer.
              auto_flag <= 1'b0;
              state     <= ST_IDLE;
              layer_out <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          // Unused encoding: recover to a quiet idle.
          state     <= ST_IDLE;
          cnt       <= '0;
          auto_flag <= 1'b0;
          layer_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scanner.sv
// tb_layer_scanner: directed plus randomized stimulus for layer_scanner,
// checked every cycle against a timeline model. The model only knows which
// layer is being served and how many cycles into its period it is; the
// expected outputs follow from the period layout (blank cycles, then hold
// cycles) with plain arithmetic.
module tb_layer_scanner;

  localparam int NL    = 6;  // not a power of two, so indices 6 and 7 are illegal
  localparam int LW    = $clog2(NL);
  localparam int HOLD  = 4;
  localparam int BLANK = 2;
`ifdef LAYER_BLANK_EN
  localparam int BL = BLANK;
`else
  localparam int BL = 0;
`endif
  localparam int PER = BL + HOLD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          auto_en = 1'b0;
  logic [LW-1:0] layer_i = '0;
  logic          busy, done, frame_done, err;
  logic [LW-1:0] cur_layer;
  logic [NL-1:0] layer_out;

  layer_scanner #(
    .NUM_LAYERS  (NL),
    .CNT_W       (16),
    .HOLD_CYCLES (HOLD),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer_i   (layer_i),
    .auto_en   (auto_en),
    .busy      (busy),
    .done      (done),
    .frame_done(frame_done),
    .err       (err),
    .cur_layer (cur_layer),
    .layer_out (layer_out)
  );

  always #5 clk = ~clk;

  // Reference model: which layer is served, whether it belongs to an auto
  // scan, and the 1-based cycle position inside that layer's period.
  bit m_busy, m_auto, m_done, m_fd, m_err;
  int m_layer, m_off;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Advance the model across one rising edge with the inputs sampled there.
  task automatic model_edge(input bit s, input int li, input bit ae, input bit rn);
    m_done = 0;
    m_fd   = 0;
    m_err  = 0;
    if (!rn) begin
      m_busy  = 0;
      m_auto  = 0;
      m_layer = 0;
      m_off   = 0;
    end else if (!m_busy) begin
      if (ae) begin
        m_busy = 1; m_auto = 1; m_layer = 0; m_off = 1;
      end else if (s) begin
        if (li < NL) begin
          m_busy = 1; m_auto = 0; m_layer = li; m_off = 1;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_off == PER) begin
      m_done = 1;
      m_fd   = m_auto && (m_layer == NL - 1);
      if (m_auto && ae) begin
        m_layer = (m_layer + 1) % NL;
        m_off   = 1;
      end else begin
        m_busy = 0;
        m_auto = 0;
      end
    end else begin
      m_off++;
    end
  endtask

  task automatic compare();
    int exp_lo;
    exp_lo = (m_busy && m_off > BL) ? (1 << m_layer) : 0;
    check("busy",       int'(busy),       int'(m_busy));
    check("done",       int'(done),       int'(m_done));
    check("frame_done", int'(frame_done), int'(m_fd));
    check("err",        int'(err),        int'(m_err));
    check("cur_layer",  int'(cur_layer),  m_layer);
    check("layer_out",  int'(layer_out),  exp_lo);
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns after the rise.
  task automatic step(input bit s, input int li, input bit ae, input bit rn);
    @(negedge clk);
    start   = s;
    layer_i = LW'(li);
    auto_en = ae;
    rst_n   = rn;
    @(posedge clk);
    model_edge(s, li, ae, rn);
    #1 compare();
  endtask

  initial begin
    bit s, ae, rn;
    int li;

    // Reset state.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Manual layer 3, then idle long enough to see done and the quiet IDLE.
    step(1, 3, 0, 1);
    for (int i = 0; i < PER + 3; i++) step(0, 0, 0, 1);

    // Back-to-back manual requests, start re-issued on the done cycle.
    step(1, 5, 0, 1);
    for (int i = 0; i < PER; i++) step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    for (int i = 0; i < PER + 1; i++) step(0, 0, 0, 1);

    // Out-of-range requests pulse err; a start during an active layer is ignored.
    step(1, 6, 0, 1);
    step(1, 7, 0, 1);
    step(1, 2, 0, 1);
    step(1, 4, 0, 1);
    for (int i = 0; i < PER + 2; i++) step(0, 0, 0, 1);

    // Auto and start together: auto wins. Run more than one full frame.
    step(1, 4, 1, 1);
    for (int i = 0; i < NL * PER + PER + 2; i++) step(0, 0, 1, 1);
    for (int i = 0; i < PER + 2; i++) step(0, 0, 0, 1);

    // Auto dropped during layer 2: that layer completes, no frame_done.
    step(0, 0, 1, 1);
    for (int i = 0; i < 2 * PER + 1; i++) step(0, 0, 1, 1);
    for (int i = 0; i < PER + 2; i++) step(0, 0, 0, 1);

    // Reset in the middle of a manual layer, then a normal request.
    step(1, 2, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < PER + 2; i++) step(0, 0, 0, 1);

    // Randomized traffic with a sticky auto_en and rare resets.
    ae = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) ae = !ae;
      s  = ($urandom_range(3) == 0);
      li = int'($urandom_range(7));
      rn = ($urandom_range(149) != 0);
      step(s, li, ae, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_scanner.md
# layer_scanner

Parametrised layer driver for the LED cube, superseding the fixed 8-layer single-shot activator. Drives exactly one layer line one-hot for a programmable hold time. Two operating modes: manual single-layer activation on `start`, and a free-running auto scan across all layers with a frame-complete pulse. Sits between the frame sequencer (which supplies layer index and column data timing) and the layer transistor drivers.

## Interface
- `NUM_LAYERS`, 8, number of layer lines; ≥2; need not be a power of two
- `LAYER_W`, $clog2(NUM_LAYERS), layer index width (derived, not overridden)
- `CNT_W`, 16, hold/blank counter width
- `HOLD_CYCLES`, 2929, active cycles per layer; 1 ≤ HOLD_CYCLES < 2^CNT_W
- `BLANK_CYCLES`, 4, dead cycles before each layer (used only with blanking compiled in); 1 ≤ BLANK_CYCLES < 2^CNT_W

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `start` in 1 — manual request; sampled only in IDLE
- `layer_i` in LAYER_W — layer index for manual request
- `auto_en` in 1 — level; enables continuous scan 0..NUM_LAYERS-1
- `busy` out 1 — high in any non-IDLE state
- `done` out 1 — 1-cycle pulse, cycle after last active cycle of each layer
- `frame_done` out 1 — 1-cycle pulse with `done` of layer NUM_LAYERS-1 in auto mode
- `err` out 1 — 1-cycle pulse on rejected manual request (`layer_i` ≥ NUM_LAYERS)
- `cur_layer` out LAYER_W — layer being blanked/driven; holds last value in IDLE
- `layer_out` out NUM_LAYERS — registered one-hot drive; all zero outside ACTIVE

## Operation
- States: IDLE, BLANK (only with blanking compiled in), ACTIVE.
- IDLE: if `auto_en`, load `cur_layer`=0, set auto flag, go BLANK/ACTIVE. Else if `start` and `layer_i` < NUM_LAYERS: load `cur_layer`=`layer_i`, clear auto flag, go BLANK/ACTIVE. Else if `start` and out of range: pulse `err`, stay IDLE.
- `auto_en` and `start` together in IDLE: auto wins, `start` dropped.
- BLANK: `layer_out`=0 for BLANK_CYCLES cycles, then ACTIVE.
- ACTIVE: `layer_out` = 1 << `cur_layer` for exactly HOLD_CYCLES cycles. At end:
  - auto flag set and `auto_en` high: `cur_layer` increments, wrapping NUM_LAYERS-1 → 0, go BLANK/ACTIVE with no IDLE cycle.
  - otherwise go IDLE.
- `start` and `layer_i` ignored outside IDLE (no `err`, no queueing).
- `auto_en` deasserted mid-layer: current layer completes its full hold, `done` pulses, return to IDLE. `frame_done` only if that layer was NUM_LAYERS-1.
- Counter: single CNT_W counter, cleared on every state entry, compared against HOLD_CYCLES-1 / BLANK_CYCLES-1.

## Timing
- Reset (rst_n low at an edge): next cycle IDLE; `busy`, `done`, `frame_done`, `err`, `layer_out` = 0; `cur_layer` = 0; counter = 0. Applies mid-BLANK/ACTIVE; no `done` issued for the aborted layer.
- Request accepted at cycle t, no blanking: `layer_out` valid t+1..t+HOLD_CYCLES; `done` at t+HOLD_CYCLES+1.
- With blanking: zeros t+1..t+BLANK_CYCLES, active t+BLANK_CYCLES+1..t+BLANK_CYCLES+HOLD_CYCLES, `done` one cycle later.
- `busy` high from t+1 through last active cycle.
- Manual: `done` cycle is IDLE; new `start` there is accepted (back-to-back period HOLD_CYCLES+1, or +BLANK_CYCLES).
- Auto: layer period HOLD_CYCLES (+BLANK_CYCLES); `done` coincides with first cycle of next layer/blank.
- `err` at cycle t+1 for a rejected request at t.

## Configuration
- `LAYER_BLANK_EN` defined: BLANK state present; every layer, manual or auto, preceded by BLANK_CYCLES zero cycles (anti-ghosting dead time).
- Not defined: BLANK state and BLANK_CYCLES unused; IDLE/ACTIVE go straight to ACTIVE; auto layers back-to-back with no gap.

## Test plan
- NUM_LAYERS=8, HOLD=4, no blank: `start`, `layer_i`=3 at cycle 0 -> `layer_out`=8'h08 cycles 1–4, `busy` 1–4, `done` at 5 only.
- Same config, `auto_en` held high from cycle 0 -> 8'h01,02,04,…,80 each 4 cycles (1–32); `done` at 5,9,…,33; `frame_done` only at 33; 8'h01 again at 33.
- `LAYER_BLANK_EN`, BLANK=2, HOLD=4: `start`, `layer_i`=0 at 0 -> zeros 1–2, 8'h01 3–6, `done` 7; auto period 6 cycles.
- NUM_LAYERS=6: `start`, `layer_i`=6 -> `err` at 1, `layer_out`=0, `busy`=0; `start` at cycle 2 during active layer ignored.
- Auto running, `auto_en` low during layer 2 -> layer 2 completes full hold, `done` pulses, IDLE, no `frame_done`.
- `rst_n` low at cycle 3 of a manual HOLD=4 layer -> cycle 4 all outputs 0, no `done`; `start` after reset accepted normally.
